// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring
// divide on operand magnitudes, sign fixup at the end, one-cycle path for special divides.
//
// state | meaning
// IDLE  | waiting for start; result and dst_out hold the last completed op
// BUSY  | one multiply/divide iteration per clock, 32 in total
// DONE  | result valid, done (and wr_en if rd != 0) high for this cycle only
module mul_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       funct3,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [4:0]       dst_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [4:0]       dst_out,
   output logic             wr_en
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2:0]         func_q, func_d;
   logic               neg_a_q, neg_a_d;
   logic               neg_b_q, neg_b_d;
   logic [WIDTH-1:0]   mag_b_q, mag_b_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic [4:0]         dst_q, dst_d;

   logic               in_is_div, in_a_sgn, in_b_sgn, in_neg_a, in_neg_b;
   logic [WIDTH-1:0]   in_mag_a, in_mag_b, fast_res;
   logic               div_by_zero, div_ovf;

   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_shift, div_rem;
   logic               div_ge;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] acc_step, prod_fix;
   logic [WIDTH-1:0]   quo, rem, final_res;

   // Operand decode for the request presented in IDLE.
   always_comb begin
      in_is_div   = funct3[2];
      in_a_sgn    = in_is_div ? ~funct3[0] : (funct3 == 3'b001 || funct3 == 3'b010);
      in_b_sgn    = in_is_div ? ~funct3[0] : (funct3 == 3'b001);
      in_neg_a    = in_a_sgn & op_a[WIDTH-1];
      in_neg_b    = in_b_sgn & op_b[WIDTH-1];
      in_mag_a    = in_neg_a ? -op_a : op_a;
      in_mag_b    = in_neg_b ? -op_b : op_b;
      div_by_zero = in_is_div && (op_b == '0);
      div_ovf     = in_is_div && !funct3[0] && (op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (op_b == '1);
      // Overflow DIV returns the dividend itself (most-negative value).
      if (div_by_zero)
         fast_res = funct3[1] ? op_a : '1;
      else
         fast_res = funct3[1] ? '0 : op_a;
   end

   // acc_q is {product_hi, multiplier} for multiply and {remainder, dividend/quotient} for divide.
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
      mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
      div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_ge    = div_shift >= {1'b0, mag_b_q};
      div_rem   = div_ge ? (div_shift - {1'b0, mag_b_q}) : div_shift;
      div_next  = {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge};
      acc_step  = func_q[2] ? div_next : mul_next;

      prod_fix  = (neg_a_q ^ neg_b_q) ? -acc_step : acc_step;
      quo       = acc_step[WIDTH-1:0];
      rem       = acc_step[2*WIDTH-1:WIDTH];
      case (func_q)
         3'b000:         final_res = prod_fix[WIDTH-1:0];
         3'b100, 3'b101: final_res = (neg_a_q ^ neg_b_q) ? -quo : quo;
         3'b110, 3'b111: final_res = neg_a_q ? -rem : rem;
         default:        final_res = prod_fix[2*WIDTH-1:WIDTH];
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      func_d   = func_q;
      neg_a_d  = neg_a_q;
      neg_b_d  = neg_b_q;
      mag_b_d  = mag_b_q;
      acc_d    = acc_q;
      result_d = result_q;
      dst_d    = dst_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               func_d  = funct3;
               dst_d   = dst_in;
               neg_a_d = in_neg_a;
               neg_b_d = in_neg_b;
               mag_b_d = in_mag_b;
               acc_d   = {{WIDTH{1'b0}}, in_mag_a};
               cnt_d   = '0;
               if (div_by_zero || div_ovf) begin
                  state_d  = DONE;
                  result_d = fast_res;
               end else begin
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            acc_d = acc_step;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH-1)) begin
               state_d  = DONE;
               result_d = final_res;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         func_q   <= '0;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         mag_b_q  <= '0;
         acc_q    <= '0;
         result_q <= '0;
         dst_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         func_q   <= func_d;
         neg_a_q  <= neg_a_d;
         neg_b_q  <= neg_b_d;
         mag_b_q  <= mag_b_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         dst_q    <= dst_d;
      end
   end

   assign busy    = (state_q != IDLE);
   assign done    = (state_q == DONE);
   assign result  = result_q;
   assign dst_out = dst_q;
   assign wr_en   = done && (dst_q != 5'd0);

endmodule
